// File: rtl/sail_core_pkg.sv
// sail_core_pkg: shared core widths, reset PC and the fetch buffer entry type
package sail_core_pkg;
   localparam int XLEN = 32;
   localparam int INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous {pc, instr} buffer with count, push/pop and flush
module fetch_fifo
   import sail_core_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           push,
   input  fetch_entry_t                   din,
   input  logic                           pop,
   output fetch_entry_t                   head,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   fetch_entry_t mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= '{default: '0};
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         assert (!(push && count == CW'(DEPTH))) else $error("fetch_fifo: push while full");
         assert (!(pop && count == '0)) else $error("fetch_fifo: pop while empty");
      end
   end
   assign head = mem[rd_ptr];
endmodule

// File: rtl/mux2.sv
// mux2: generic 2:1 multiplexer
module mux2 #(
   parameter int W = 32
) (
   input  logic         sel,
   input  logic [W-1:0] in0,
   input  logic [W-1:0] in1,
   output logic [W-1:0] y
);
   assign y = sel ? in1 : in0;
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the PC, issues in-order imem requests and buffers fetched
// instructions for decode; redirects flush buffered and in-flight fetches.
module fetch_pc_unit
   import sail_core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   output logic            fetch_valid,
   output logic [XLEN-1:0] fetch_pc,
   output logic [XLEN-1:0] fetch_instr,
   input  logic            fetch_ready
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   logic [XLEN-1:0] pc, pc_next, inflight_pc, stall_addr;
   logic inflight, kill, accept, push, pop, stall_q;
   logic [CW-1:0] count;
   fetch_entry_t head;
   assign fetch_valid = !rst && !redirect_valid && count != '0;
   assign pop = fetch_valid && fetch_ready;
   // credit: buffered + in-flight entries must leave room for the next response
   assign imem_req_valid = !rst && !redirect_valid &&
      ({1'b0, count} + (CW+1)'(inflight)) < ((CW+1)'(FIFO_DEPTH) + (CW+1)'(pop));
   assign imem_req_addr = pc;
   assign accept = imem_req_valid && imem_req_ready;
   assign push = imem_resp_valid && inflight && !kill && !redirect_valid && !rst;
   assign fetch_pc = head.pc;
   assign fetch_instr = head.instr;
   mux2 #(.W(XLEN)) u_next_pc (
      .sel(redirect_valid),
      .in0(pc + XLEN'(INSTR_BYTES)),
      .in1(align_pc(redirect_pc)),
      .y  (pc_next)
   );
   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .flush(redirect_valid),
      .push (push),
      .din  ('{pc: inflight_pc, instr: imem_resp_data}),
      .pop  (pop),
      .head (head),
      .count(count)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
         inflight <= 1'b0;
         inflight_pc <= '0;
         kill <= 1'b0;
      end else begin
         if (redirect_valid || accept) pc <= pc_next;
         if (accept) begin
            inflight <= 1'b1;
            inflight_pc <= pc;
            kill <= 1'b0;
         end else begin
            if (imem_resp_valid) inflight <= 1'b0;
            if (redirect_valid && inflight) kill <= 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      stall_q <= imem_req_valid && !imem_req_ready;
      stall_addr <= pc;
      if (!rst) begin
         assert (!(imem_resp_valid && !inflight)) else $error("fetch_pc_unit: response without request");
         if (stall_q && imem_req_valid)
            assert (imem_req_addr == stall_addr) else $error("fetch_pc_unit: address changed while stalled");
      end
   end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed + random stimulus against a queue-based fetch stream model
module tb_fetch_pc_unit;
   import sail_core_pkg::*;
   localparam logic [31:0] RPC = 32'h0000_0100;
   localparam int D = 2;
   logic clk = 1'b0;
   logic rst, redirect_valid, imem_req_valid, imem_req_ready, imem_resp_valid;
   logic fetch_valid, fetch_ready;
   logic [31:0] redirect_pc, imem_req_addr, imem_resp_data, fetch_pc, fetch_instr;
   int n_chk = 0, n_fail = 0;
   logic [63:0] q [$];
   logic [31:0] m_pc, m_infl_pc, pend_addr;
   bit m_infl, m_live, pend;
   always #5 clk = ~clk;
   fetch_pc_unit #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .fetch_valid    (fetch_valid),
      .fetch_pc       (fetch_pc),
      .fetch_instr    (fetch_instr),
      .fetch_ready    (fetch_ready)
   );
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // one clock: drive at negedge, check settled outputs, advance the model at posedge
   task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy, input bit fr);
      bit ef, ep, er, acc;
      logic [31:0] old_pc;
      @(negedge clk);
      rst = r;
      redirect_valid = rv;
      redirect_pc = rpc;
      imem_req_ready = rdy;
      fetch_ready = fr;
      imem_resp_valid = pend;
      imem_resp_data = pend ? mem_f(pend_addr) : $urandom;
      #1;
      ef = !r && !rv && q.size() > 0;
      ep = ef && fr;
      er = !r && !rv && (q.size() + int'(m_infl) - int'(ep) < D);
      check("imem_req_valid", 32'(imem_req_valid), 32'(er));
      check("imem_req_addr", imem_req_addr, m_pc);
      check("fetch_valid", 32'(fetch_valid), 32'(ef));
      if (ef) begin
         check("fetch_pc", fetch_pc, q[0][63:32]);
         check("fetch_instr", fetch_instr, q[0][31:0]);
      end
      acc = er && rdy;
      old_pc = m_pc;
      @(posedge clk);
      if (r) begin
         q.delete();
         m_pc = RPC;
         m_infl = 0;
         m_live = 0;
      end else begin
         if (ep) void'(q.pop_front());
         if (pend && m_infl && m_live && !rv) q.push_back({m_infl_pc, imem_resp_data});
         if (rv) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_infl) m_live = 0;
         end else if (acc) m_pc = old_pc + 32'd4;
         if (acc) begin
            m_infl = 1;
            m_live = 1;
            m_infl_pc = old_pc;
         end else if (pend) m_infl = 0;
      end
      pend = acc;
      pend_addr = old_pc;
   endtask
   initial begin
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem_req_ready = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data = '0;
      fetch_ready = 1'b0;
      m_pc = RPC;
      m_infl_pc = '0;
      pend_addr = '0;
      m_infl = 0;
      m_live = 0;
      pend = 0;
      repeat (3) step(1, 0, 0, 1, 1);
      #1;
      check("rst_fetch_pc", fetch_pc, 32'h0);
      check("rst_fetch_instr", fetch_instr, 32'h0);
      check("rst_req_addr", imem_req_addr, RPC);
      check("rst_fetch_valid", 32'(fetch_valid), 32'h0);
      repeat (8) step(0, 0, 0, 1, 1);
      repeat (5) step(0, 0, 0, 1, 0);
      repeat (4) step(0, 0, 0, 1, 1);
      repeat (3) step(0, 0, 0, 0, 1);
      repeat (3) step(0, 0, 0, 1, 1);
      repeat (2) step(0, 0, 0, 1, 0);
      step(0, 1, 32'h0000_0203, 1, 0);
      repeat (5) step(0, 0, 0, 1, 1);
      step(0, 1, 32'h0000_0400, 1, 1);
      step(0, 1, 32'h0000_0502, 1, 1);
      repeat (4) step(0, 0, 0, 1, 1);
      step(0, 1, 32'hFFFF_FFF9, 1, 1);
      repeat (5) step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      step(1, 0, 0, 1, 1);
      repeat (4) step(0, 0, 0, 1, 1);
      repeat (400)
         step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom,
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
